scale_access_sequencer: RTL and testbench

//  Sequences memory accesses for one 2x image-scale pass: walks the source image and emits read

---
 rtl/scale_access_sequencer_pkg.sv | 40 ++++
 rtl/pixel_coord_counter.sv | 85 ++++++++
 rtl/scale_access_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_scale_access_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_access_sequencer_pkg.sv
// Purpose : shared operation codes, FSM state encoding and group-shape helpers
//           for the 2x scale access sequencer.
// Contents: op_e, state_e, is_enlarge(), reads_per_group(), writes_per_group().
package scale_access_sequencer_pkg;

   // operation[2] selects enlarge (1) / reduce (0); [1:0] selects the filter
   typedef enum logic [2:0] {
      OP_RNB = 3'b000,
      OP_RPR = 3'b001,
      OP_RAM = 3'b010,
      OP_RDM = 3'b011,
      OP_WNB = 3'b100,
      OP_WPR = 3'b101,
      OP_WAM = 3'b110,
      OP_WDM = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic is_enlarge(input logic [2:0] op);
      return op[2];
   endfunction

   // Only reduce+AM averages a 2x2 block; every other mode reads one pixel
   function automatic logic [2:0] reads_per_group(input logic [2:0] op);
      return (op == OP_RAM) ? 3'd4 : 3'd1;
   endfunction

   // Enlarge replicates each source pixel into a 2x2 block
   function automatic logic [2:0] writes_per_group(input logic [2:0] op);
      return op[2] ? 3'd4 : 3'd1;
   endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Purpose : nested x/y group counter that tracks the source and destination
//           base address of the current group via row-base accumulators.
// Latency : registered; o_*_addr/o_last reflect the group after each i_step.
// Backpr. : advances only on i_step; i_clear reloads the first group.
// Ports   : i_clear/i_step control, i_x_last/i_y_last grid limits, *_inc step
//           sizes; o_src_addr/o_dst_addr group bases, o_src_next next-group
//           source base (valid before the step), o_last on the final group.
module pixel_coord_counter #(
   parameter int                ADDR_W   = 17,
   parameter int                X_W      = 8,
   parameter int                Y_W      = 7,
   parameter logic [ADDR_W-1:0] SRC_BASE = '0,
   parameter logic [ADDR_W-1:0] DST_BASE = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_clear,
   input  logic              i_step,
   input  logic [X_W-1:0]    i_x_last,
   input  logic [Y_W-1:0]    i_y_last,
   input  logic [ADDR_W-1:0] i_src_col_inc,
   input  logic [ADDR_W-1:0] i_src_row_inc,
   input  logic [ADDR_W-1:0] i_dst_col_inc,
   input  logic [ADDR_W-1:0] i_dst_row_inc,
   output logic [ADDR_W-1:0] o_src_addr,
   output logic [ADDR_W-1:0] o_dst_addr,
   output logic [ADDR_W-1:0] o_src_next,
   output logic              o_last
);

   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [ADDR_W-1:0] r_src_row;
   logic [ADDR_W-1:0] r_src_cur;
   logic [ADDR_W-1:0] r_dst_row;
   logic [ADDR_W-1:0] r_dst_cur;

   logic              w_x_wrap;
   logic [ADDR_W-1:0] w_src_row_nxt;
   logic [ADDR_W-1:0] w_dst_row_nxt;
   logic [ADDR_W-1:0] w_src_next;
   logic [ADDR_W-1:0] w_dst_next;

   assign w_x_wrap      = (r_x == i_x_last);
   assign w_src_row_nxt = r_src_row + i_src_row_inc;
   assign w_dst_row_nxt = r_dst_row + i_dst_row_inc;
   // On a row wrap the next group starts at the following row base
   assign w_src_next    = w_x_wrap ? w_src_row_nxt : (r_src_cur + i_src_col_inc);
   assign w_dst_next    = w_x_wrap ? w_dst_row_nxt : (r_dst_cur + i_dst_col_inc);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_x       <= '0;
         r_y       <= '0;
         r_src_row <= '0;
         r_src_cur <= '0;
         r_dst_row <= '0;
         r_dst_cur <= '0;
      end else if (i_clear) begin
         r_x       <= '0;
         r_y       <= '0;
         r_src_row <= SRC_BASE;
         r_src_cur <= SRC_BASE;
         r_dst_row <= DST_BASE;
         r_dst_cur <= DST_BASE;
      end else if (i_step) begin
         r_src_cur <= w_src_next;
         r_dst_cur <= w_dst_next;
         if (w_x_wrap) begin
            r_x       <= '0;
            r_y       <= r_y + 1'b1;
            r_src_row <= w_src_row_nxt;
            r_dst_row <= w_dst_row_nxt;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   assign o_src_addr = r_src_cur;
   assign o_dst_addr = r_dst_cur;
   assign o_src_next = w_src_next;
   assign o_last     = w_x_wrap && (r_y == i_y_last);

endmodule

// File: rtl/scale_access_sequencer.sv
// Purpose : sequences source reads and destination writes for one 2x scale pass.
// Latency : busy one cycle after start; per group R reads + RD_LAT wait + Wn writes.
// Backpr. : grant=0 stalls READ/WRITE with strobes low and addresses held.
// Ports   : clock/reset_n; start+operation launch a pass; grant gates the memory
//           port; src_addr/src_rd_en/rd_idx read side; dst_addr/dst_wr_en write
//           side; busy during a pass; done one-cycle completion pulse.
module scale_access_sequencer
   import scale_access_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 17,
   parameter int SRC_W    = 160,
   parameter int SRC_H    = 120,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 19200,
   parameter int RD_LAT   = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [2:0]        operation,
   input  logic              grant,
   output logic [ADDR_W-1:0] src_addr,
   output logic              src_rd_en,
   output logic [1:0]        rd_idx,
   output logic [ADDR_W-1:0] dst_addr,
   output logic              dst_wr_en,
   output logic              busy,
   output logic              done
);

   localparam int X_W = (SRC_W > 2) ? $clog2(SRC_W) : 1;
   localparam int Y_W = (SRC_H > 2) ? $clog2(SRC_H) : 1;

   localparam logic [ADDR_W-1:0] L_ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] L_TWO      = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] L_SRC_W    = ADDR_W'(SRC_W);
   localparam logic [ADDR_W-1:0] L_SRC_W_X2 = ADDR_W'(2 * SRC_W);
   localparam logic [ADDR_W-1:0] L_SRC_W_X4 = ADDR_W'(4 * SRC_W);
   localparam logic [ADDR_W-1:0] L_SRC_W_H  = ADDR_W'(SRC_W / 2);
   localparam logic [ADDR_W-1:0] L_SRC_BASE = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] L_DST_BASE = ADDR_W'(DST_BASE);
   localparam logic [X_W-1:0]    L_XL_RED   = X_W'(SRC_W / 2 - 1);
   localparam logic [X_W-1:0]    L_XL_ENL   = X_W'(SRC_W - 1);
   localparam logic [Y_W-1:0]    L_YL_RED   = Y_W'(SRC_H / 2 - 1);
   localparam logic [Y_W-1:0]    L_YL_ENL   = Y_W'(SRC_H - 1);
   localparam logic [2:0]        L_WAIT_END = 3'(RD_LAT - 1);

   state_e            r_state;
   logic [2:0]        r_op;
   logic [1:0]        r_rd_idx;
   logic [1:0]        r_wr_idx;
   logic [2:0]        r_wait;
   logic [ADDR_W-1:0] r_src_addr;
   logic [ADDR_W-1:0] r_dst_addr;
   logic              r_busy;
   logic              r_done;

   logic              w_enl;
   logic              w_rd_last;
   logic              w_wr_last;
   logic [1:0]        w_rd_nxt;
   logic [1:0]        w_wr_nxt;
   logic [ADDR_W-1:0] w_src_off;
   logic [ADDR_W-1:0] w_dst_off;
   logic              w_clear;
   logic              w_step;
   logic [ADDR_W-1:0] w_src_grp;
   logic [ADDR_W-1:0] w_dst_grp;
   logic [ADDR_W-1:0] w_src_next;
   logic              w_last;

   assign w_enl     = is_enlarge(r_op);
   assign w_rd_last = ({1'b0, r_rd_idx} == (reads_per_group(r_op) - 3'd1));
   assign w_wr_last = ({1'b0, r_wr_idx} == (writes_per_group(r_op) - 3'd1));
   assign w_rd_nxt  = r_rd_idx + 2'd1;
   assign w_wr_nxt  = r_wr_idx + 2'd1;

   // Within-group offsets: bit0 steps one column, bit1 steps one row.
   // Only 4-access groups reach idx 1..3, so the row pitch here is the one
   // for that shape (source pitch for reads, enlarged pitch for writes).
   assign w_src_off = (w_rd_nxt[0] ? L_ONE : '0) + (w_rd_nxt[1] ? L_SRC_W : '0);
   assign w_dst_off = (w_wr_nxt[0] ? L_ONE : '0) + (w_wr_nxt[1] ? L_SRC_W_X2 : '0);

   assign w_clear = (r_state == ST_IDLE) && start;
   assign w_step  = (r_state == ST_WRITE) && grant && w_wr_last && !w_last;

   pixel_coord_counter #(
      .ADDR_W   (ADDR_W),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .SRC_BASE (L_SRC_BASE),
      .DST_BASE (L_DST_BASE)
   ) u_group_walk (
      .clock         (clock),
      .reset_n       (reset_n),
      .i_clear       (w_clear),
      .i_step        (w_step),
      .i_x_last      (w_enl ? L_XL_ENL : L_XL_RED),
      .i_y_last      (w_enl ? L_YL_ENL : L_YL_RED),
      .i_src_col_inc (w_enl ? L_ONE : L_TWO),
      .i_src_row_inc (w_enl ? L_SRC_W : L_SRC_W_X2),
      .i_dst_col_inc (w_enl ? L_TWO : L_ONE),
      .i_dst_row_inc (w_enl ? L_SRC_W_X4 : L_SRC_W_H),
      .o_src_addr    (w_src_grp),
      .o_dst_addr    (w_dst_grp),
      .o_src_next    (w_src_next),
      .o_last        (w_last)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_rd_idx   <= '0;
         r_wr_idx   <= '0;
         r_wait     <= '0;
         r_src_addr <= '0;
         r_dst_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_op       <= operation;
                  r_busy     <= 1'b1;
                  r_rd_idx   <= '0;
                  r_src_addr <= L_SRC_BASE;
                  r_state    <= ST_READ;
               end
            end
            ST_READ: begin
               if (grant) begin
                  if (w_rd_last) begin
                     r_wait  <= '0;
                     r_state <= ST_WAIT;
                  end else begin
                     r_rd_idx   <= w_rd_nxt;
                     r_src_addr <= w_src_grp + w_src_off;
                  end
               end
            end
            ST_WAIT: begin
               // Fixed read latency; the port is not used here so grant is ignored
               if (r_wait == L_WAIT_END) begin
                  r_wr_idx   <= '0;
                  r_dst_addr <= w_dst_grp;
                  r_state    <= ST_WRITE;
               end else begin
                  r_wait <= r_wait + 3'd1;
               end
            end
            ST_WRITE: begin
               if (grant) begin
                  if (w_wr_last) begin
                     if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end else begin
                        // Counter steps on this same edge; take its next-group base
                        r_rd_idx   <= '0;
                        r_src_addr <= w_src_next;
                        r_state    <= ST_READ;
                     end
                  end else begin
                     r_wr_idx   <= w_wr_nxt;
                     r_dst_addr <= w_dst_grp + w_dst_off;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobes follow grant combinationally so an ungranted cycle never issues
   assign src_rd_en = (r_state == ST_READ) && grant;
   assign dst_wr_en = (r_state == ST_WRITE) && grant;
   assign src_addr  = r_src_addr;
   assign dst_addr  = r_dst_addr;
   assign rd_idx    = r_rd_idx;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_scale_access_sequencer.sv
// Purpose : directed self-checking bench for scale_access_sequencer on a 4x4 image.
// Latency : n/a (bench).
// Backpr. : drives grant directly to exercise stalls.
module tb_scale_access_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  operation;
   logic        grant;
   logic [16:0] src_addr;
   logic        src_rd_en;
   logic [1:0]  rd_idx;
   logic [16:0] dst_addr;
   logic        dst_wr_en;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int rb = 0;
   int wb = 0;
   int db = 0;
   int both_cnt = 0;

   int rd_a[$];
   int rd_i[$];
   int rd_c[$];
   int wr_a[$];
   int wr_c[$];
   int done_c[$];

   int exp_rd[$];
   int exp_ri[$];
   int exp_rc[$];
   int exp_wr[$];
   int exp_wc[$];
   int exp_done;

   scale_access_sequencer #(
      .ADDR_W   (17),
      .SRC_W    (4),
      .SRC_H    (4),
      .SRC_BASE (0),
      .DST_BASE (32),
      .RD_LAT   (2)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .operation (operation),
      .grant     (grant),
      .src_addr  (src_addr),
      .src_rd_en (src_rd_en),
      .rd_idx    (rd_idx),
      .dst_addr  (dst_addr),
      .dst_wr_en (dst_wr_en),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Trace recorder, sampled mid-cycle
   always @(negedge clock) begin
      if (src_rd_en) begin
         rd_a.push_back(int'(src_addr));
         rd_i.push_back(int'(rd_idx));
         rd_c.push_back(cyc);
      end
      if (dst_wr_en) begin
         wr_a.push_back(int'(dst_addr));
         wr_c.push_back(cyc);
      end
      if (done) done_c.push_back(cyc);
      if (src_rd_en && dst_wr_en) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic start_pass(input logic [2:0] op);
      step_cycle();
      rb = rd_a.size();
      wb = wr_a.size();
      db = done_c.size();
      operation = op;
      start = 1'b1;
      t0 = cyc;
      #1;
      chk("busy_before_start", busy, 0);
      step_cycle();
      start = 1'b0;
      #1;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      n = 0;
      while ((done_c.size() == db) && (n < limit)) begin
         step_cycle();
         n++;
      end
      repeat (3) step_cycle();
      chk($sformatf("%s_done_count", tag), done_c.size() - db, 1);
      chk($sformatf("%s_done_cycle", tag),
          (done_c.size() > db) ? (done_c[db] - t0) : -1, exp_done);
      chk($sformatf("%s_busy_end", tag), busy, 0);
   endtask

   task automatic compare_log(input string tag);
      chk($sformatf("%s_rd_count", tag), rd_a.size() - rb, exp_rd.size());
      for (int i = 0; i < exp_rd.size() && (rb + i) < rd_a.size(); i++) begin
         chk($sformatf("%s_rd_addr[%0d]", tag, i), rd_a[rb + i], exp_rd[i]);
         chk($sformatf("%s_rd_idx[%0d]", tag, i), rd_i[rb + i], exp_ri[i]);
         chk($sformatf("%s_rd_cyc[%0d]", tag, i), rd_c[rb + i] - t0, exp_rc[i]);
      end
      chk($sformatf("%s_wr_count", tag), wr_a.size() - wb, exp_wr.size());
      for (int i = 0; i < exp_wr.size() && (wb + i) < wr_a.size(); i++) begin
         chk($sformatf("%s_wr_addr[%0d]", tag, i), wr_a[wb + i], exp_wr[i]);
         chk($sformatf("%s_wr_cyc[%0d]", tag, i), wr_c[wb + i] - t0, exp_wc[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      operation = 3'b000;
      grant     = 1'b1;

      // Reset state
      repeat (2) step_cycle();
      chk("rst_src_addr", src_addr, 0);
      chk("rst_dst_addr", dst_addr, 0);
      chk("rst_src_rd_en", src_rd_en, 0);
      chk("rst_dst_wr_en", dst_wr_en, 0);
      chk("rst_rd_idx", rd_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset_n = 1'b1;
      repeat (2) step_cycle();

      // Scenario 1: reduce + AM
      exp_rd = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
      exp_ri = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      exp_rc = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18, 22, 23, 24, 25};
      exp_wr = '{32, 33, 34, 35};
      exp_wc = '{7, 14, 21, 28};
      exp_done = 29;
      start_pass(3'b010);
      wait_done("s1", 200);
      compare_log("s1");
      chk("s1_src_hold", src_addr, 15);
      chk("s1_dst_hold", dst_addr, 35);

      // Scenario 2: enlarge + NB, spot checks on first and last group
      exp_done = 113;
      start_pass(3'b100);
      wait_done("s2", 400);
      chk("s2_rd_count", rd_a.size() - rb, 16);
      chk("s2_wr_count", wr_a.size() - wb, 64);
      if ((rd_a.size() - rb) == 16 && (wr_a.size() - wb) == 64) begin
         chk("s2_rd_first", rd_a[rb], 0);
         chk("s2_wr0", wr_a[wb + 0], 32);
         chk("s2_wr1", wr_a[wb + 1], 33);
         chk("s2_wr2", wr_a[wb + 2], 40);
         chk("s2_wr3", wr_a[wb + 3], 41);
         chk("s2_rd_last", rd_a[rb + 15], 15);
         chk("s2_wr60", wr_a[wb + 60], 86);
         chk("s2_wr61", wr_a[wb + 61], 87);
         chk("s2_wr62", wr_a[wb + 62], 94);
         chk("s2_wr63", wr_a[wb + 63], 95);
      end

      // Scenario 3: reduce + NB
      exp_rd = '{0, 2, 8, 10};
      exp_ri = '{0, 0, 0, 0};
      exp_rc = '{1, 5, 9, 13};
      exp_wr = '{32, 33, 34, 35};
      exp_wc = '{4, 8, 12, 16};
      exp_done = 17;
      start_pass(3'b000);
      wait_done("s3", 200);
      compare_log("s3");

      // Scenario 4: grant dropped for 3 cycles after the 2nd read
      exp_rd = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
      exp_ri = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      exp_rc = '{1, 2, 6, 7, 11, 12, 13, 14, 18, 19, 20, 21, 25, 26, 27, 28};
      exp_wr = '{32, 33, 34, 35};
      exp_wc = '{10, 17, 24, 31};
      exp_done = 32;
      start_pass(3'b010);
      step_cycle();
      step_cycle();
      grant = 1'b0;
      #1;
      chk("s4_no_rd_when_ungranted", src_rd_en, 0);
      chk("s4_addr_held", src_addr, 4);
      repeat (3) step_cycle();
      grant = 1'b1;
      #1;
      chk("s4_rd_on_regrant", src_rd_en, 1);
      chk("s4_rd_idx_on_regrant", rd_idx, 2);
      wait_done("s4", 200);
      compare_log("s4");

      // Scenario 5: start and operation disturbed while busy
      exp_rc = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18, 22, 23, 24, 25};
      exp_wc = '{7, 14, 21, 28};
      exp_done = 29;
      start_pass(3'b010);
      step_cycle();
      step_cycle();
      start = 1'b1;
      operation = 3'b100;
      step_cycle();
      start = 1'b0;
      wait_done("s5", 200);
      compare_log("s5");

      // Scenario 6: reset in the middle of a WRITE
      start_pass(3'b100);
      repeat (4) step_cycle();
      #1;
      chk("s6_in_write", dst_wr_en, 1);
      chk("s6_write_addr", dst_addr, 33);
      reset_n = 1'b0;
      #1;
      chk("s6_rst_src_addr", src_addr, 0);
      chk("s6_rst_dst_addr", dst_addr, 0);
      chk("s6_rst_rd_en", src_rd_en, 0);
      chk("s6_rst_wr_en", dst_wr_en, 0);
      chk("s6_rst_rd_idx", rd_idx, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_done", done, 0);
      repeat (2) step_cycle();
      reset_n = 1'b1;
      rb = rd_a.size();
      wb = wr_a.size();
      db = done_c.size();
      repeat (6) step_cycle();
      chk("s6_idle_no_reads", rd_a.size() - rb, 0);
      chk("s6_idle_no_writes", wr_a.size() - wb, 0);
      chk("s6_idle_no_done", done_c.size() - db, 0);
      chk("s6_idle_busy", busy, 0);
      exp_rd = '{0, 2, 8, 10};
      exp_ri = '{0, 0, 0, 0};
      exp_rc = '{1, 5, 9, 13};
      exp_wr = '{32, 33, 34, 35};
      exp_wc = '{4, 8, 12, 16};
      exp_done = 17;
      start_pass(3'b000);
      wait_done("s6", 200);
      compare_log("s6");

      chk("never_both_strobes", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
